// File: rtl/mult_arbiter_pkg.sv
// Shared widths and helpers for the multiplier arbiter.
// Operand/product widths, signed operand type, tag-width function.
package mult_arbiter_pkg;

   localparam int OP_W   = 16;
   localparam int PROD_W = 32;

   typedef logic signed [OP_W-1:0]   op_t;
   typedef logic signed [PROD_W-1:0] prod_t;

   // Width of a requester index; never below one bit.
   function automatic int tag_w(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/mult_arbiter_if.sv
// Bus between requesters, the arbiter and the external multiplier.
// slave: arbiter side; master: requesters plus multiplier side.
interface mult_arbiter_if #(
   parameter int N_REQ = 4
);
   import mult_arbiter_pkg::*;

   logic [N_REQ-1:0]      req_valid;
   logic [N_REQ-1:0]      req_ready;
   logic [OP_W*N_REQ-1:0] req_a;
   logic [OP_W*N_REQ-1:0] req_b;
   logic [OP_W-1:0]       mul_a;
   logic [OP_W-1:0]       mul_b;
   logic                  mul_en;
   logic [PROD_W-1:0]     mul_p;
   logic [N_REQ-1:0]      rsp_valid;
   logic [PROD_W-1:0]     rsp_p;

   modport slave (
      input  req_valid, req_a, req_b, mul_p,
      output req_ready, mul_a, mul_b, mul_en,
      output rsp_valid, rsp_p
   );

   modport master (
      output req_valid, req_a, req_b, mul_p,
      input  req_ready, mul_a, mul_b, mul_en,
      input  rsp_valid, rsp_p
   );

endinterface

// File: rtl/mult_arbiter_rr_grant.sv
// Round-robin one-hot grant starting the search at ptr.
// Ports: req (request vector), ptr (start index), gnt (one-hot).
module rr_grant #(
   parameter int N  = 4,
   parameter int PW = 2
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  gnt
);

   logic [2*N-1:0] dbl;
   logic [N-1:0]   rot;
   logic [N-1:0]   pick;
   logic [2*N-1:0] back;

   // Rotate so ptr sits at bit 0, pick the lowest set bit,
   // then rotate the one-hot back into place.
   always_comb begin
      dbl  = {req, req} >> ptr;
      rot  = dbl[N-1:0];
      pick = '0;
      for (int k = N - 1; k >= 0; k--) begin
         if (rot[k]) pick = N'(1) << k;
      end
      back = {pick, pick} << ptr;
      gnt  = back[2*N-1:N];
   end

endmodule

// File: rtl/mult_arbiter.sv
// Round-robin front end sharing one external multiplier
// (booth4_wallace_mult16) among N_REQ requesters.
// Ports: sys_clk, sys_rst (async, active high),
//        bus (req_*, mul_*, rsp_* on the slave modport).
module mult_arbiter
   import mult_arbiter_pkg::*;
#(
   parameter int N_REQ    = 4,
   parameter int MULT_LAT = 2
) (
   input  logic          sys_clk,
   input  logic          sys_rst,
   mult_arbiter_if.slave bus
);

   localparam int TW = tag_w(N_REQ);

   logic [TW-1:0]             rr_ptr;
   logic [TW-1:0]             ptr_nxt;
   logic [TW-1:0]             gnt_idx;
   logic [N_REQ-1:0]          req_act;
   logic [N_REQ-1:0]          gnt;
   logic                      hs;
   op_t                       sel_a;
   op_t                       sel_b;
   op_t                       mul_a_q;
   op_t                       mul_b_q;
   logic [MULT_LAT:0]         tag_vld;
   logic [MULT_LAT:0][TW-1:0] tag_idx;

   // No grant is offered while reset is held.
   assign req_act = bus.req_valid & {N_REQ{~sys_rst}};

   rr_grant #(
      .N  (N_REQ),
      .PW (TW)
   ) u_rr_grant (
      .req (req_act),
      .ptr (rr_ptr),
      .gnt (gnt)
   );

   assign bus.req_ready = gnt;

   // gnt is only ever set on a valid line, so any bit is a handshake.
   assign hs = |gnt;

   always_comb begin
      gnt_idx = '0;
      sel_a   = '0;
      sel_b   = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (gnt[i]) begin
            gnt_idx = TW'(i);
            sel_a   = bus.req_a[i*OP_W +: OP_W];
            sel_b   = bus.req_b[i*OP_W +: OP_W];
         end
      end
   end

   assign ptr_nxt = (gnt_idx == TW'(N_REQ - 1))
                  ? '0 : gnt_idx + 1'b1;

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         rr_ptr  <= '0;
         mul_a_q <= '0;
         mul_b_q <= '0;
      end else if (hs) begin
         rr_ptr  <= ptr_nxt;
         mul_a_q <= sel_a;
         mul_b_q <= sel_b;
      end
   end

   // Stage 0 lines up with mul_en; stage MULT_LAT with mul_p.
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         tag_vld <= '0;
         tag_idx <= '0;
      end else begin
         tag_vld[0] <= hs;
         tag_idx[0] <= gnt_idx;
         for (int k = 1; k <= MULT_LAT; k++) begin
            tag_vld[k] <= tag_vld[k-1];
            tag_idx[k] <= tag_idx[k-1];
         end
      end
   end

   assign bus.mul_en = tag_vld[0];
   assign bus.mul_a  = mul_a_q;
   assign bus.mul_b  = mul_b_q;

   // Combinational so a zero-latency multiplier still lines up.
   always_comb begin
      bus.rsp_valid = '0;
      bus.rsp_p     = '0;
      if (tag_vld[MULT_LAT]) begin
         bus.rsp_valid = N_REQ'(1) << tag_idx[MULT_LAT];
         bus.rsp_p     = bus.mul_p;
      end
   end

endmodule

// File: tb/tb_mult_arbiter.sv
// Bench for mult_arbiter: directed scenarios plus random traffic
// against a queue-based model; also a zero-latency build.
module tb_mult_arbiter;
   import mult_arbiter_pkg::*;

   localparam int N   = 4;
   localparam int LAT = 2;

   typedef struct {
      int idx;
      int p;
      int due;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_cmp = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;

   mult_arbiter_if #(.N_REQ(N)) bus ();
   mult_arbiter_if #(.N_REQ(N)) bus0 ();

   mult_arbiter #(
      .N_REQ    (N),
      .MULT_LAT (LAT)
   ) dut (
      .sys_clk (clk),
      .sys_rst (rst),
      .bus     (bus)
   );

   mult_arbiter #(
      .N_REQ    (N),
      .MULT_LAT (0)
   ) dut0 (
      .sys_clk (clk),
      .sys_rst (rst),
      .bus     (bus0)
   );

   // Stand-in for the external pipelined multiplier.
   logic [31:0] mp [LAT];
   always @(posedge clk) begin
      mp[0] <= int'($signed(bus.mul_a)) * int'($signed(bus.mul_b));
      for (int k = 1; k < LAT; k++) mp[k] <= mp[k-1];
   end
   assign bus.mul_p  = mp[LAT-1];
   assign bus0.mul_p = int'($signed(bus0.mul_a))
                     * int'($signed(bus0.mul_b));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      bus.req_valid  = '0;
      bus0.req_valid = '0;
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      bus.req_valid = '1;
      bus.req_a     = '1;
      bus.req_b     = '1;
      rst = 1'b1;
      tick();
      tick();
      #1;
      n_cmp++;
      if ({bus.req_ready, bus.mul_en, bus.mul_a, bus.mul_b,
           bus.rsp_valid, bus.rsp_p} !== '0) begin
         n_bad++;
         $display("FAIL reset_outs: rdy=%b en=%b a=%h b=%h rv=%b p=%h want 0",
                  bus.req_ready, bus.mul_en, bus.mul_a, bus.mul_b,
                  bus.rsp_valid, bus.rsp_p);
      end
      bus.req_valid = '0;
      rst = 1'b0;
   endtask

   task automatic test_single();
      do_reset();
      bus.req_a = '0;
      bus.req_b = '0;
      bus.req_a[32 +: 16] = 16'h0003;
      bus.req_b[32 +: 16] = 16'hFFFB;
      bus.req_valid = 4'b0100;
      #1;
      n_cmp++;
      if (bus.req_ready !== 4'b0100) begin
         n_bad++;
         $display("FAIL single_ready: got %b want 0100", bus.req_ready);
      end
      tick();
      bus.req_valid = '0;
      #1;
      n_cmp++;
      if ({bus.mul_en, bus.mul_a, bus.mul_b}
          !== {1'b1, 16'h0003, 16'hFFFB}) begin
         n_bad++;
         $display("FAIL single_issue: en=%b a=%h b=%h want 1 0003 fffb",
                  bus.mul_en, bus.mul_a, bus.mul_b);
      end
      tick();
      n_cmp++;
      if ({bus.mul_en, bus.mul_a, bus.mul_b, bus.rsp_valid}
          !== {1'b0, 16'h0003, 16'hFFFB, 4'b0000}) begin
         n_bad++;
         $display("FAIL single_hold: en=%b a=%h b=%h rv=%b",
                  bus.mul_en, bus.mul_a, bus.mul_b, bus.rsp_valid);
      end
      tick();
      n_cmp++;
      if ({bus.rsp_valid, bus.rsp_p} !== {4'b0100, 32'hFFFF_FFF1}) begin
         n_bad++;
         $display("FAIL single_rsp: rv=%b p=%h want 0100 fffffff1",
                  bus.rsp_valid, bus.rsp_p);
      end
      tick();
      n_cmp++;
      if (bus.rsp_valid !== 4'b0000) begin
         n_bad++;
         $display("FAIL single_once: rv=%b want 0000", bus.rsp_valid);
      end
   endtask

   task automatic test_rotation();
      int ra;
      int rb;
      logic [3:0]  er;
      logic [31:0] ep;
      do_reset();
      for (int i = 0; i < N; i++) begin
         ra = i * 1000 + 7;
         rb = -(i + 3) * 211;
         bus.req_a[i*16 +: 16] = 16'(ra);
         bus.req_b[i*16 +: 16] = 16'(rb);
      end
      bus.req_valid = '1;
      for (int c = 0; c < 8 + LAT + 2; c++) begin
         if (c == 8) bus.req_valid = '0;
         #1;
         er = (c < 8) ? 4'(1 << (c % N)) : 4'b0000;
         n_cmp++;
         if (bus.req_ready !== er) begin
            n_bad++;
            $display("FAIL rot_grant c=%0d: got %b want %b",
                     c, bus.req_ready, er);
         end
         if (c >= LAT + 1 && c < 8 + LAT + 1) begin
            ra = (c - LAT - 1) % N;
            er = 4'(1 << ra);
            ep = 32'((ra * 1000 + 7) * (-(ra + 3) * 211));
         end else begin
            er = 4'b0000;
            ep = '0;
         end
         n_cmp++;
         if (bus.rsp_valid !== er
             || (er != 0 && bus.rsp_p !== ep)) begin
            n_bad++;
            $display("FAIL rot_rsp c=%0d: rv=%b p=%h want %b %h",
                     c, bus.rsp_valid, bus.rsp_p, er, ep);
         end
         tick();
      end
   endtask

   task automatic test_wrap();
      do_reset();
      bus.req_valid = 4'b0100;
      tick();
      bus.req_valid = 4'b1001;
      #1;
      n_cmp++;
      if (bus.req_ready !== 4'b1000) begin
         n_bad++;
         $display("FAIL wrap_g3: got %b want 1000", bus.req_ready);
      end
      tick();
      n_cmp++;
      if (bus.req_ready !== 4'b0001) begin
         n_bad++;
         $display("FAIL wrap_g0: got %b want 0001", bus.req_ready);
      end
      tick();
      n_cmp++;
      if (bus.req_ready !== 4'b1000) begin
         n_bad++;
         $display("FAIL wrap_g3b: got %b want 1000", bus.req_ready);
      end
      bus.req_valid = '0;
      repeat (LAT + 2) tick();
   endtask

   task automatic test_extremes();
      do_reset();
      bus.req_a[0 +: 16]  = 16'h8000;
      bus.req_b[0 +: 16]  = 16'h8000;
      bus.req_a[16 +: 16] = 16'h7FFF;
      bus.req_b[16 +: 16] = 16'h8000;
      bus.req_valid = 4'b0001;
      tick();
      bus.req_valid = 4'b0010;
      tick();
      bus.req_valid = '0;
      tick();
      n_cmp++;
      if ({bus.rsp_valid, bus.rsp_p} !== {4'b0001, 32'h4000_0000}) begin
         n_bad++;
         $display("FAIL ext_minmin: rv=%b p=%h want 0001 40000000",
                  bus.rsp_valid, bus.rsp_p);
      end
      tick();
      n_cmp++;
      if ({bus.rsp_valid, bus.rsp_p} !== {4'b0010, 32'hC000_8000}) begin
         n_bad++;
         $display("FAIL ext_maxmin: rv=%b p=%h want 0010 c0008000",
                  bus.rsp_valid, bus.rsp_p);
      end
      repeat (2) tick();
   endtask

   task automatic test_random();
      exp_t        q[$];
      int          ptr;
      int          g;
      int          j;
      logic [N-1:0] v;
      logic [15:0] a [N];
      logic [15:0] b [N];
      logic        exp_en;
      logic [15:0] ea;
      logic [15:0] eb;
      logic [N-1:0] er;
      logic [31:0] ep;
      ptr    = 0;
      exp_en = 1'b0;
      ea     = '0;
      eb     = '0;
      do_reset();
      for (int c = 0; c < 300 + LAT + 2; c++) begin
         if (c >= 300)         v = '0;
         else if (c % 50 < 10) v = '1;
         else                  v = N'($urandom);
         for (int i = 0; i < N; i++) begin
            a[i] = ($urandom_range(0, 7) == 0) ? 16'h8000
                                               : 16'($urandom);
            b[i] = ($urandom_range(0, 7) == 0) ? 16'h7FFF
                                               : 16'($urandom);
            bus.req_a[i*16 +: 16] = a[i];
            bus.req_b[i*16 +: 16] = b[i];
         end
         bus.req_valid = v;
         #1;
         g = -1;
         for (int k = 0; k < N; k++) begin
            j = (ptr + k) % N;
            if (g < 0 && v[j]) g = j;
         end
         er = (g < 0) ? '0 : N'(1) << g;
         n_cmp++;
         if (bus.req_ready !== er) begin
            n_bad++;
            $display("FAIL rnd_grant c=%0d: got %b want %b",
                     c, bus.req_ready, er);
         end
         n_cmp++;
         if ({bus.mul_en, bus.mul_a, bus.mul_b} !== {exp_en, ea, eb}) begin
            n_bad++;
            $display("FAIL rnd_issue c=%0d: got %b %h %h want %b %h %h",
                     c, bus.mul_en, bus.mul_a, bus.mul_b, exp_en, ea, eb);
         end
         er = '0;
         ep = '0;
         if (q.size() > 0 && q[0].due == c) begin
            er = N'(1) << q[0].idx;
            ep = 32'(q[0].p);
            void'(q.pop_front());
         end
         n_cmp++;
         if (bus.rsp_valid !== er
             || (er != 0 && bus.rsp_p !== ep)) begin
            n_bad++;
            $display("FAIL rnd_rsp c=%0d: rv=%b p=%h want %b %h",
                     c, bus.rsp_valid, bus.rsp_p, er, ep);
         end
         exp_en = (g >= 0);
         if (g >= 0) begin
            ea = a[g];
            eb = b[g];
            q.push_back('{g,
                          int'($signed(a[g])) * int'($signed(b[g])),
                          c + 1 + LAT});
            ptr = (g + 1) % N;
         end
         tick();
      end
   endtask

   task automatic test_reset_flight();
      do_reset();
      bus.req_valid = 4'b0010;
      tick();
      bus.req_valid = 4'b0100;
      tick();
      bus.req_valid = 4'b1000;
      #2;
      rst = 1'b1;
      #1;
      n_cmp++;
      if ({bus.req_ready, bus.mul_en, bus.mul_a, bus.mul_b,
           bus.rsp_valid, bus.rsp_p} !== '0) begin
         n_bad++;
         $display("FAIL flight_rst: rdy=%b en=%b a=%h b=%h rv=%b p=%h want 0",
                  bus.req_ready, bus.mul_en, bus.mul_a, bus.mul_b,
                  bus.rsp_valid, bus.rsp_p);
      end
      #2;
      bus.req_valid = '0;
      rst = 1'b0;
      for (int c = 0; c < LAT + 3; c++) begin
         tick();
         n_cmp++;
         if ({bus.mul_en, bus.rsp_valid} !== 5'b0) begin
            n_bad++;
            $display("FAIL flight_drop c=%0d: en=%b rv=%b want 0",
                     c, bus.mul_en, bus.rsp_valid);
         end
      end
      bus.req_valid = '1;
      #1;
      n_cmp++;
      if (bus.req_ready !== 4'b0001) begin
         n_bad++;
         $display("FAIL flight_first: got %b want 0001", bus.req_ready);
      end
      tick();
      bus.req_valid = '0;
      repeat (LAT + 2) tick();
   endtask

   task automatic test_lat0();
      int p;
      do_reset();
      bus0.req_a = '0;
      bus0.req_b = '0;
      bus0.req_a[16 +: 16] = 16'(-1234);
      bus0.req_b[16 +: 16] = 16'(77);
      p = -1234 * 77;
      bus0.req_valid = 4'b0010;
      #1;
      n_cmp++;
      if (bus0.req_ready !== 4'b0010) begin
         n_bad++;
         $display("FAIL lat0_ready: got %b want 0010", bus0.req_ready);
      end
      tick();
      bus0.req_valid = '0;
      #1;
      n_cmp++;
      if ({bus0.mul_en, bus0.rsp_valid, bus0.rsp_p}
          !== {1'b1, 4'b0010, 32'(p)}) begin
         n_bad++;
         $display("FAIL lat0_rsp: en=%b rv=%b p=%h want 1 0010 %h",
                  bus0.mul_en, bus0.rsp_valid, bus0.rsp_p, 32'(p));
      end
      tick();
      n_cmp++;
      if ({bus0.mul_en, bus0.rsp_valid} !== 5'b0) begin
         n_bad++;
         $display("FAIL lat0_once: en=%b rv=%b want 0",
                  bus0.mul_en, bus0.rsp_valid);
      end
   endtask

   initial begin
      bus.req_valid  = '0;
      bus.req_a      = '0;
      bus.req_b      = '0;
      bus0.req_valid = '0;
      bus0.req_a     = '0;
      bus0.req_b     = '0;
      test_reset();
      test_single();
      test_rotation();
      test_wrap();
      test_extremes();
      test_random();
      test_reset_flight();
      test_lat0();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/mult_arbiter.md
MULT_ARBITER -- requirements
Module: mult_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters sharing the multiplier; legal range 2..8.
REQ-002 Parameter MULT_LAT, default 2: fixed cycles from mul_en to valid mul_p; legal range 0..4.
REQ-003 One clock, sys_clk; reset sys_rst is asynchronous and active-high.
REQ-004 sys_clk  input  1  clock; all state updates on rising edge.
REQ-005 sys_rst  input  1  asynchronous active-high reset.
REQ-006 req_valid  input  N_REQ  per-requester operand-pair valid.
REQ-007 req_a  input  16*N_REQ  multiplicands, requester i at bits [16i+15:16i], signed two's complement.
REQ-008 req_b  input  16*N_REQ  multipliers, same packing and signedness as req_a.
REQ-009 req_ready  output  N_REQ  one-hot grant; handshake when req_valid[i] & req_ready[i].
REQ-010 mul_a  output  16  registered operand A to the shared multiplier.
REQ-011 mul_b  output  16  registered operand B to the shared multiplier.
REQ-012 mul_en  output  1  one-cycle pulse marking mul_a/mul_b as a new operation.
REQ-013 mul_p  input  32  signed product from the multiplier, valid MULT_LAT cycles after mul_en.
REQ-014 rsp_valid  output  N_REQ  one-hot result strobe to the originating requester; no backpressure.
REQ-015 rsp_p  output  32  product, valid only while any rsp_valid bit is high.

Function
REQ-016 Arbitration SHALL be round-robin: search starts at pointer rr_ptr and wraps from N_REQ-1 to 0.
REQ-017 req_ready SHALL be combinational from req_valid and rr_ptr; at most one bit high; zero when no req_valid.
REQ-018 req_ready[i] SHALL NOT depend on req_a/req_b.
REQ-019 After a handshake with requester g, rr_ptr SHALL become (g+1) mod N_REQ; without a handshake it holds.
REQ-020 One handshake SHALL be accepted per cycle; throughput is one operation per cycle, with no stall.
REQ-021 On a handshake, the next cycle SHALL present the granted operands on mul_a/mul_b with mul_en=1.
REQ-022 mul_a/mul_b SHALL hold their last values when mul_en=0.
REQ-023 A tag (requester index plus valid bit) SHALL travel through a MULT_LAT-deep shift register aligned to mul_en.
REQ-024 When the tag emerges, rsp_valid[tag] SHALL be 1 for exactly one cycle and rsp_p SHALL equal mul_p in that cycle.
REQ-025 Latency from handshake edge to rsp_valid SHALL be exactly 1+MULT_LAT cycles.
REQ-026 Responses SHALL return in acceptance order.
REQ-027 With MULT_LAT=0, rsp_valid SHALL coincide with mul_en, and rsp_p SHALL be the same-cycle mul_p.
REQ-028 A requester deasserting req_valid before it is granted SHALL be legal; that request is dropped.
REQ-029 If all requesters are valid continuously, grants SHALL rotate 0,1,...,N_REQ-1,0,...

Reset
REQ-030 Asserting sys_rst SHALL immediately set rr_ptr=0, mul_en=0, mul_a=0, mul_b=0, all tag valids=0, rsp_valid=0 and rsp_p=0.
REQ-031 While sys_rst=1, req_ready SHALL be 0.
REQ-032 Operations in flight at reset SHALL be discarded, with no rsp_valid after reset release.
REQ-033 The first grant after release SHALL follow REQ-016 with rr_ptr=0.

Structure
REQ-034 The shared package SHALL hold: operand width 16, product width 32, and the tag-width function clog2(N_REQ).
REQ-035 Round-robin grant logic SHALL be a sub-module rr_grant: inputs req vector and pointer, output one-hot grant.
REQ-036 The multiplier itself SHALL be outside this block; the top level connects mul_* to booth4_wallace_mult16.

Verification
REQ-037 Scenario: N_REQ=4, MULT_LAT=2; req 2 alone sends a=3, b=-5 -> req_ready=0100, mul_en next cycle, rsp_valid=0100 with rsp_p=-15 three cycles after the handshake.
REQ-038 Scenario: all four valid for 8 cycles -> grant order 0,1,2,3,0,1,2,3; 8 responses in the same order, one per cycle.
REQ-039 Scenario: rr_ptr=3, only reqs 0 and 3 valid -> grant 3, then 0; wrap-around verified.
REQ-040 Scenario: a=-32768, b=-32768 -> rsp_p=0x40000000; a=32767, b=-32768 -> rsp_p=0xC0008000.
REQ-041 Scenario: assert sys_rst mid-cycle with 2 operations in flight -> outputs zero immediately, no rsp_valid afterwards; the next request is granted from requester 0 first.
REQ-042 Scenario: MULT_LAT=0 build, single request -> rsp_valid in the cycle after the handshake.
